// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared core types: FSM encoding, register index width, hazard hit helper
package cpu_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  // A producer only matters when it really writes a non-$0 register.
  function automatic logic reg_hit(input logic [REG_W-1:0] src,
                                   input logic [REG_W-1:0] dst,
                                   input logic             we);
    return (src != REG_ZERO) && (src == dst) && we;
  endfunction

endpackage

// File: rtl/stall_unit_if.sv
// rtl/stall_unit_if.sv - pipeline-side view of the interlock: hazard inputs, stage controls, counters
interface stall_unit_if #(parameter int CNT_WIDTH = 32);
  import cpu_pkg::*;

  logic [REG_W-1:0]     ID_rs, ID_rt, EX_RW, MEM_RW;
  logic                 ID_rs_used, ID_rt_used, ID_branch, ID_taken, ID_halt;
  logic                 EX_regwe, MEM_regwe, EX_memread, MEM_memread, resume;
  logic                 PC_en, IF_ID_en, IF_ID_flush, ID_EX_bubble, halted;
  logic [CNT_WIDTH-1:0] cycle_cnt, stall_cnt, flush_cnt;

  modport master (
    output ID_rs, ID_rt, ID_rs_used, ID_rt_used, ID_branch, ID_taken, ID_halt,
           EX_RW, MEM_RW, EX_regwe, MEM_regwe, EX_memread, MEM_memread, resume,
    input  PC_en, IF_ID_en, IF_ID_flush, ID_EX_bubble, halted,
           cycle_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    input  ID_rs, ID_rt, ID_rs_used, ID_rt_used, ID_branch, ID_taken, ID_halt,
           EX_RW, MEM_RW, EX_regwe, MEM_regwe, EX_memread, MEM_memread, resume,
    output PC_en, IF_ID_en, IF_ID_flush, ID_EX_bubble, halted,
           cycle_cnt, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/perf_counter.sv
// rtl/perf_counter.sv - wrapping event counter with synchronous clear
module perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr)     count <= '0;
    else if (en) count <= count + W'(1);
  end

endmodule

// File: rtl/stall_unit.sv
// rtl/stall_unit.sv - load-use / branch-operand interlock, redirect flush, halt drain FSM, perf counters
module stall_unit
  import cpu_pkg::*;
#(
  parameter int CNT_WIDTH    = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic         clk,
  input  logic         rst,
  stall_unit_if.slave  bus
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

  state_t        state;
  logic [DW-1:0] drain_cnt;
  logic          halted_q;

  logic ex_hit, mem_hit, load_use, br_ex, br_mem_load;
  logic run, stall, halt_go, taken_q;

  assign ex_hit  = (bus.ID_rs_used && reg_hit(bus.ID_rs, bus.EX_RW, bus.EX_regwe)) ||
                   (bus.ID_rt_used && reg_hit(bus.ID_rt, bus.EX_RW, bus.EX_regwe));
  assign mem_hit = (bus.ID_rs_used && reg_hit(bus.ID_rs, bus.MEM_RW, bus.MEM_regwe)) ||
                   (bus.ID_rt_used && reg_hit(bus.ID_rt, bus.MEM_RW, bus.MEM_regwe));

  // ID-stage forwarding sees MEM ALU results only, so a branch also waits on loads in MEM.
  assign load_use    = ex_hit && bus.EX_memread;
  assign br_ex       = bus.ID_branch && ex_hit;
  assign br_mem_load = bus.ID_branch && mem_hit && bus.MEM_memread;

  assign run     = (state == RUN);
  assign stall   = run && (load_use || br_ex || br_mem_load);
  assign halt_go = run && bus.ID_halt && !stall;
  assign taken_q = run && bus.ID_taken && !bus.ID_halt && !stall;

  assign bus.PC_en        = run && !stall;
  assign bus.IF_ID_en     = run && !stall;
  assign bus.ID_EX_bubble = !run || stall;
  assign bus.IF_ID_flush  = taken_q;
  assign bus.halted       = halted_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= DRAIN_INIT;
      halted_q  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          drain_cnt <= DRAIN_INIT;
          if (halt_go) state <= DRAIN;
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state    <= HALTED;
            halted_q <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        HALTED: begin
          if (bus.resume) begin
            state    <= RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state    <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  perf_counter #(.W(CNT_WIDTH)) u_cycle_cnt (
    .clk(clk), .clr(rst), .en(state != HALTED), .count(bus.cycle_cnt)
  );
  perf_counter #(.W(CNT_WIDTH)) u_stall_cnt (
    .clk(clk), .clr(rst), .en(stall), .count(bus.stall_cnt)
  );
  perf_counter #(.W(CNT_WIDTH)) u_flush_cnt (
    .clk(clk), .clr(rst), .en(taken_q), .count(bus.flush_cnt)
  );

endmodule

// File: tb/tb_stall_unit.sv
// tb/tb_stall_unit.sv - directed vectors for stall_unit with hand-computed expectations
module tb_stall_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  stall_unit_if #(.CNT_WIDTH(32)) bus ();

  stall_unit #(.CNT_WIDTH(32), .DRAIN_CYCLES(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ID_rs = '0;  bus.ID_rt = '0;  bus.ID_rs_used = 0; bus.ID_rt_used = 0;
    bus.ID_branch = 0; bus.ID_taken = 0; bus.ID_halt = 0;
    bus.EX_RW = '0;  bus.MEM_RW = '0; bus.EX_regwe = 0; bus.MEM_regwe = 0;
    bus.EX_memread = 0; bus.MEM_memread = 0; bus.resume = 0;
  endtask

  task automatic ctl(input string tag, input logic pc, input logic bub,
                     input logic fl, input logic hlt);
    #1;
    check({tag, ".PC_en"},        bus.PC_en,        pc);
    check({tag, ".IF_ID_en"},     bus.IF_ID_en,     pc);
    check({tag, ".ID_EX_bubble"}, bus.ID_EX_bubble, bub);
    check({tag, ".IF_ID_flush"},  bus.IF_ID_flush,  fl);
    check({tag, ".halted"},       bus.halted,       hlt);
  endtask

  task automatic cnts(input string tag, input int cyc, input int stl, input int fls);
    check({tag, ".cycle_cnt"}, bus.cycle_cnt, cyc);
    check({tag, ".stall_cnt"}, bus.stall_cnt, stl);
    check({tag, ".flush_cnt"}, bus.flush_cnt, fls);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
    ctl("reset", 1, 0, 0, 0);
    cnts("reset", 0, 0, 0);

    // load-use: lw $2 in EX, ID reads $2
    bus.EX_RW = 5'd2; bus.EX_regwe = 1; bus.EX_memread = 1;
    bus.ID_rs = 5'd2; bus.ID_rs_used = 1;
    ctl("load_use", 0, 1, 0, 0);
    step();
    idle_inputs();
    bus.MEM_RW = 5'd2; bus.MEM_regwe = 1; bus.MEM_memread = 1;
    bus.ID_rs = 5'd2; bus.ID_rs_used = 1;
    ctl("load_use_after", 1, 0, 0, 0);
    cnts("load_use_after", 1, 1, 0);
    step();

    // $0 writer never stalls
    idle_inputs();
    bus.EX_RW = 5'd0; bus.EX_regwe = 1; bus.EX_memread = 1;
    bus.ID_rs = 5'd0; bus.ID_rs_used = 1; bus.ID_branch = 1;
    ctl("zero_reg", 1, 0, 0, 0);
    step();

    // ALU result in EX feeding a branch via rt: unused rt ignored, used rt stalls
    idle_inputs();
    bus.EX_RW = 5'd7; bus.EX_regwe = 1; bus.ID_rt = 5'd7; bus.ID_branch = 1;
    ctl("br_ex_unused", 1, 0, 0, 0);
    bus.ID_rt_used = 1;
    ctl("br_ex_rt", 0, 1, 0, 0);
    step();
    cnts("br_ex_rt", 4, 2, 0);

    // lw $3 then taken beq $3: two stalls, flush only on the third cycle
    idle_inputs();
    bus.EX_RW = 5'd3; bus.EX_regwe = 1; bus.EX_memread = 1;
    bus.ID_rs = 5'd3; bus.ID_rs_used = 1; bus.ID_branch = 1; bus.ID_taken = 1;
    ctl("ld_br_1", 0, 1, 0, 0);
    step();
    bus.EX_RW = '0; bus.EX_regwe = 0; bus.EX_memread = 0;
    bus.MEM_RW = 5'd3; bus.MEM_regwe = 1; bus.MEM_memread = 1;
    ctl("ld_br_2", 0, 1, 0, 0);
    cnts("ld_br_2", 5, 3, 0);
    step();
    bus.MEM_RW = '0; bus.MEM_regwe = 0; bus.MEM_memread = 0;
    ctl("ld_br_3", 1, 0, 1, 0);
    cnts("ld_br_3", 6, 4, 0);
    step();
    cnts("after_flush", 7, 4, 1);

    // halt + taken behind a load-use: stall first, then halt wins over taken
    idle_inputs();
    bus.EX_RW = 5'd4; bus.EX_regwe = 1; bus.EX_memread = 1;
    bus.ID_rs = 5'd4; bus.ID_rs_used = 1; bus.ID_halt = 1; bus.ID_taken = 1;
    ctl("halt_stall", 0, 1, 0, 0);
    step();
    bus.EX_RW = '0; bus.EX_regwe = 0; bus.EX_memread = 0;
    ctl("halt_accept", 1, 0, 0, 0);
    step();
    idle_inputs();
    bus.resume = 1;
    ctl("drain1", 0, 1, 0, 0);
    cnts("drain1", 9, 5, 1);
    step();
    ctl("drain2", 0, 1, 0, 0);
    step();
    bus.resume = 0;
    ctl("drain3", 0, 1, 0, 0);
    step();
    ctl("halted", 0, 1, 0, 1);
    check("halted.cycle_cnt", bus.cycle_cnt, 12);
    step();
    check("frozen.cycle_cnt", bus.cycle_cnt, 12);
    bus.resume = 1;
    ctl("resume_req", 0, 1, 0, 1);
    step();
    bus.resume = 0;
    ctl("resumed", 1, 0, 0, 0);
    check("resumed.cycle_cnt", bus.cycle_cnt, 12);
    step();
    check("run_again.cycle_cnt", bus.cycle_cnt, 13);

    // reset in the middle of a drain
    bus.ID_halt = 1;
    step();
    bus.ID_halt = 0;
    ctl("rdrain1", 0, 1, 0, 0);
    step();
    rst = 1; bus.ID_halt = 1; bus.resume = 1;
    step();
    rst = 0;
    idle_inputs();
    ctl("post_rst", 1, 0, 0, 0);
    cnts("post_rst", 0, 0, 0);
    repeat (4) step();
    ctl("post_rst_run", 1, 0, 0, 0);
    check("post_rst_run.cycle_cnt", bus.cycle_cnt, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
